// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction fetch path:
//   fetch_state_e    - fetch_unit FSM encoding (IDLE, FETCH, HOLD, DRAIN)
//   pc_src_e         - next-PC source select driven by the control unit
//   RESET_PC_DEFAULT - default first fetch address after reset
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_DRAIN = 2'b11
  } fetch_state_e;

  // PC_RSVD behaves exactly like PC_SEQ.
  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JUMP = 2'b01,
    PC_JR   = 2'b10,
    PC_RSVD = 2'b11
  } pc_src_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/pc_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
// Combinational redirect decision and target address for a resolving
// control-flow instruction.
//   resolve_valid_i  qualifies all other inputs this cycle
//   branch_i         instruction is a conditional branch
//   cond_zero_i      branch is taken when zero_i equals this value
//   zero_i           ALU zero flag of the resolving instruction
//   pc_src_i         PC_SEQ / PC_JUMP / PC_JR (PC_RSVD acts as PC_SEQ)
//   ex_pc4_i         pc+4 of the resolving instruction
//   ex_imm_i         16-bit branch offset in words
//   ex_target_i      26-bit jump index
//   ex_rs_i          register target for jr
//   redirect_o       fetch must restart at target_o
//   target_o         redirect address (32-bit wrap-around)
// -----------------------------------------------------------------------------
module pc_target_calc
  import mips_pkg::*;
(
  input  logic        resolve_valid_i,
  input  logic        branch_i,
  input  logic        cond_zero_i,
  input  logic        zero_i,
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] ex_pc4_i,
  input  logic [15:0] ex_imm_i,
  input  logic [25:0] ex_target_i,
  input  logic [31:0] ex_rs_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  logic        branch_taken;
  logic [31:0] branch_target;

  assign branch_taken  = branch_i && (zero_i == cond_zero_i);
  assign branch_target = ex_pc4_i + {{14{ex_imm_i[15]}}, ex_imm_i, 2'b00};

  // Jumps take priority over a branch that happens to be flagged alongside.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and a latch is never inferred.
    redirect_o = 1'b0;
    target_o   = branch_target;
    case (pc_src_e'(pc_src_i))
      PC_JUMP: begin
        redirect_o = resolve_valid_i;
        target_o   = {ex_pc4_i[31:28], ex_target_i, 2'b00};
      end
      PC_JR: begin
        redirect_o = resolve_valid_i;
        target_o   = ex_rs_i;
      end
      default: begin
        redirect_o = resolve_valid_i && branch_taken;
        target_o   = branch_target;
      end
    endcase
  end

endmodule : pc_target_calc

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: issues word requests to instruction memory, keeps
// the IF/ID register (instr/pcPlus4/instrValid) and redirects on resolved
// jumps and taken branches. A one-entry skid buffer absorbs the word that
// returns while decode is stalled.
//   clk, rst                  clock, asynchronous active-high reset
//   imemReq/imemAddr          memory request and word address
//   imemReady/imemData        read completion and returned word
//   stall                     decode cannot accept; IF/ID holds
//   resolveValid, Branch, condZero, zero, pcSrc,
//   exPc4, exImm, exTarget, exRs  redirect information from execute
//   instr, opcode, funct, pcPlus4, instrValid   IF/ID outputs
// -----------------------------------------------------------------------------
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        resolveValid,
  input  logic        Branch,
  input  logic        condZero,
  input  logic        zero,
  input  logic [1:0]  pcSrc,
  input  logic [31:0] exPc4,
  input  logic [15:0] exImm,
  input  logic [25:0] exTarget,
  input  logic [31:0] exRs,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pcPlus4,
  output logic        instrValid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc4_q, skid_pc4_d;

  logic         redirect;
  logic [31:0]  target;

  pc_target_calc u_target (
    .resolve_valid_i (resolveValid),
    .branch_i        (Branch),
    .cond_zero_i     (condZero),
    .zero_i          (zero),
    .pc_src_i        (pcSrc),
    .ex_pc4_i        (exPc4),
    .ex_imm_i        (exImm),
    .ex_target_i     (exTarget),
    .ex_rs_i         (exRs),
    .redirect_o      (redirect),
    .target_o        (target)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    imemReq      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (redirect) pc_d = target;
      end

      ST_FETCH: begin
        imemReq = 1'b1;
        if (redirect) begin
          // Whatever is in flight or in IF/ID is wrong-path now.
          pc_d    = target;
          valid_d = 1'b0;
          if (!imemReady) begin
            // Memory still owes us a word for the old address; keep
            // presenting it until it arrives, then throw it away.
            drain_addr_d = pc_q;
            state_d      = ST_DRAIN;
          end
        end else if (imemReady) begin
          pc_d = pc_q + 32'd4;
          if (!valid_q || !stall) begin
            instr_d = imemData;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = imemData;
            skid_pc4_d   = pc_q + 32'd4;
            state_d      = ST_HOLD;
          end
        end else if (!stall) begin
          // Decode took the current word and no new one arrived.
          valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end else if (!stall) begin
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        imemReq = 1'b1;
        if (redirect) pc_d = target;
        if (imemReady) state_d = ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
      // NOTE: the skid buffer is a plain register pair, not a RAM, so it is
      // cleared with everything else and never exposes stale data.
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign imemAddr   = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign instr      = instr_q;
  assign opcode     = instr_q[31:26];
  assign funct      = instr_q[5:0];
  assign pcPlus4    = pc4_q;
  assign instrValid = valid_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Memory returns word == address. Expected
// IF/ID contents are queued by the stimulus; a negedge monitor pops one entry
// whenever decode accepts an instruction (instrValid && !stall).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic        stall;
  logic        resolveValid;
  logic        Branch;
  logic        condZero;
  logic        zero;
  logic [1:0]  pcSrc;
  logic [31:0] exPc4;
  logic [15:0] exImm;
  logic [25:0] exTarget;
  logic [31:0] exRs;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pcPlus4;
  logic        instrValid;

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb_q[$];

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemReady    (imemReady),
    .imemData     (imemData),
    .stall        (stall),
    .resolveValid (resolveValid),
    .Branch       (Branch),
    .condZero     (condZero),
    .zero         (zero),
    .pcSrc        (pcSrc),
    .exPc4        (exPc4),
    .exImm        (exImm),
    .exTarget     (exTarget),
    .exRs         (exRs),
    .instr        (instr),
    .opcode       (opcode),
    .funct        (funct),
    .pcPlus4      (pcPlus4),
    .instrValid   (instrValid)
  );

  always #5 clk = ~clk;

  // Memory model: every word holds its own address.
  assign imemData = imemAddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p4);
    exp_t e;
    e.instr = i;
    e.pc4   = p4;
    sb_q.push_back(e);
  endtask

  task automatic no_resolve();
    resolveValid = 1'b0;
    Branch       = 1'b0;
    condZero     = 1'b0;
    zero         = 1'b0;
    pcSrc        = 2'b00;
  endtask

  // Scoreboard monitor: decode consumes IF/ID on an edge with instrValid && !stall.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && instrValid && !stall) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got instr %h pcPlus4 %h, expected none", instr, pcPlus4);
      end else begin
        e = sb_q.pop_front();
        check("sb_instr", instr, e.instr);
        check("sb_pcplus4", pcPlus4, e.pc4);
        check("sb_opcode_funct", {20'h0, opcode, funct}, {20'h0, e.instr[31:26], e.instr[5:0]});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1;
    imemReady = 1'b1;
    stall = 1'b0;
    exPc4 = '0;
    exImm = '0;
    exTarget = '0;
    exRs = '0;
    no_resolve();

    // Reset state.
    step();
    step();
    check("rst_req", imemReq, 1'b0);
    check("rst_addr", imemAddr, 32'h0);
    check("rst_valid", instrValid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_pcplus4", pcPlus4, 32'h0);

    // Sequential stream 0,4,8 one per cycle after IDLE.
    push(32'h0, 32'h4);
    push(32'h4, 32'h8);
    push(32'h8, 32'hC);
    rst = 1'b0;
    check("idle_req", imemReq, 1'b0);
    step();                                   // IDLE -> FETCH
    check("fetch0_req", imemReq, 1'b1);
    check("fetch0_addr", imemAddr, 32'h0);
    step();
    check("seq_addr4", imemAddr, 32'h4);
    step();
    step();                                   // instr=8, pc=0xC

    // beq taken: 0x10 + (-2 << 2) = 0x08.
    resolveValid = 1'b1; Branch = 1'b1; condZero = 1'b1; zero = 1'b1;
    exPc4 = 32'h10; exImm = 16'hFFFE;
    step();
    no_resolve();
    check("beq_addr", imemAddr, 32'h8);
    check("beq_valid", instrValid, 1'b0);
    push(32'h8, 32'hC);
    step();
    check("beq_refill_valid", instrValid, 1'b1);

    // bne not taken (condZero=0, zero=1): stream continues.
    resolveValid = 1'b1; Branch = 1'b1; condZero = 1'b0; zero = 1'b1;
    exPc4 = 32'h10; exImm = 16'h0004;
    push(32'hC, 32'h10);
    push(32'h10, 32'h14);
    step();
    no_resolve();
    check("bne_addr", imemAddr, 32'h10);
    step();                                   // instr=0x10, pc=0x14

    // jr to 0x400 while memory is slow for three cycles.
    imemReady = 1'b0;
    resolveValid = 1'b1; pcSrc = 2'b10; exRs = 32'h400;
    step();
    no_resolve();
    check("jr_hold_addr", imemAddr, 32'h14);
    check("jr_drain_req", imemReq, 1'b1);
    check("jr_valid", instrValid, 1'b0);
    step();
    step();
    check("jr_hold_addr3", imemAddr, 32'h14);
    imemReady = 1'b1;                         // stale word for 0x14 arrives
    step();
    check("jr_new_addr", imemAddr, 32'h400);
    check("jr_discard_valid", instrValid, 1'b0);
    push(32'h400, 32'h404);
    push(32'h404, 32'h408);
    step();                                   // instr=0x400

    // Stall four cycles with memory always ready.
    stall = 1'b1;
    step();
    check("stall_req", imemReq, 1'b0);
    check("stall_instr", instr, 32'h400);
    check("stall_pcplus4", pcPlus4, 32'h404);
    check("stall_valid", instrValid, 1'b1);
    step();
    step();
    step();
    check("stall_req4", imemReq, 1'b0);
    check("stall_instr4", instr, 32'h400);
    stall = 1'b0;
    step();                                   // buffered 0x404 moves out
    check("unstall_req", imemReq, 1'b1);
    check("unstall_addr", imemAddr, 32'h408);
    step();                                   // instr=0x408, pc=0x40C

    // Jump concurrent with stall: 0x408 is flushed, never consumed.
    stall = 1'b1;
    resolveValid = 1'b1; pcSrc = 2'b01;
    exPc4 = 32'h1000_0004; exTarget = 26'h100;
    step();
    no_resolve();
    stall = 1'b0;
    check("jmp_addr", imemAddr, 32'h1000_0400);
    check("jmp_valid", instrValid, 1'b0);
    push(32'h1000_0400, 32'h1000_0404);
    push(32'h1000_0404, 32'h1000_0408);
    step();
    step();
    imemReady = 1'b0;
    step();                                   // FETCH waiting on memory

    // Reset in the middle of an outstanding request.
    #2;
    rst = 1'b1;
    #1;
    check("midrst_req", imemReq, 1'b0);
    check("midrst_addr", imemAddr, 32'h0);
    check("midrst_valid", instrValid, 1'b0);
    rst = 1'b0;
    imemReady = 1'b1;
    push(32'h0, 32'h4);
    push(32'h4, 32'h8);
    step();                                   // IDLE: returning data ignored
    check("postrst_valid", instrValid, 1'b0);
    check("postrst_addr", imemAddr, 32'h0);
    step();
    step();
    imemReady = 1'b0;
    step();
    step();

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 imemReq  output  1  instruction-memory request.
REQ-005 imemAddr  output  32  request address, word-aligned.
REQ-006 imemReady  input  1  read complete; imemData valid this cycle.
REQ-007 imemData  input  32  fetched instruction word.
REQ-008 stall  input  1  decode stage cannot accept; hold instr/pcPlus4/instrValid.
REQ-009 resolveValid  input  1  qualifies Branch/condZero/zero/pcSrc/targets this cycle.
REQ-010 Branch, condZero  input  1 each  control_unit branch outputs.
REQ-011 zero  input  1  ALU zero flag of resolving instruction.
REQ-012 pcSrc  input  2  00 sequential, 01 jump/jal, 10 jr, 11 reserved (treated as 00).
REQ-013 exPc4  input  32  pc+4 of resolving instruction.
REQ-014 exImm  input  16  branch offset; exTarget  input  26  jump index; exRs  input  32  jr target.
REQ-015 instr  output  32  IF/ID instruction register.
REQ-016 opcode  output  6  instr[31:26]; funct  output  6  instr[5:0] (combinational from instr).
REQ-017 pcPlus4  output  32  address of instr plus 4.
REQ-018 instrValid  output  1  instr/pcPlus4 hold a live instruction.

Function
REQ-019 redirect = resolveValid and (pcSrc in {01,10} or (Branch and zero==condZero)); pcSrc takes priority over Branch.
REQ-020 Target: 01 -> {exPc4[31:28], exTarget, 2'b00}; 10 -> exRs; branch -> exPc4 + (sign-extended exImm << 2); 32-bit wrap-around, no overflow flag.
REQ-021 FSM states IDLE, FETCH, HOLD, DRAIN.
REQ-022 IDLE: imemReq=0; unconditionally to FETCH next cycle.
REQ-023 FETCH: imemReq=1, imemAddr=pc; imemAddr stays stable while imemReq high and imemReady low.
REQ-024 FETCH, imemReady, no redirect, (!instrValid or !stall): instr<=imemData, pcPlus4<=pc+4, instrValid<=1, pc<=pc+4; stay FETCH; one instruction per cycle sustained.
REQ-025 FETCH, imemReady, no redirect, instrValid and stall: word to skid buffer, pc<=pc+4, go HOLD.
REQ-026 FETCH, redirect, imemReady: discard data, pc<=target, instrValid<=0, stay FETCH.
REQ-027 FETCH, redirect, !imemReady: pc<=target, instrValid<=0, go DRAIN.
REQ-028 HOLD: imemReq=0; !stall -> output<=buffer, instrValid<=1, go FETCH; redirect -> drop buffer, pc<=target, instrValid<=0, go FETCH.
REQ-029 DRAIN: imemReq=1 at old imemAddr; imemReady -> discard, go FETCH; further redirect updates pc, stay DRAIN.
REQ-030 Redirect overrides stall same cycle: instrValid=0 after the edge.
REQ-031 Latency: imemReady at edge N with free output -> instrValid=1 after edge N.
REQ-032 Stall with no redirect: instr, pcPlus4, instrValid unchanged.

Reset
REQ-033 rst asserted: state IDLE, pc=RESET_PC, imemAddr=RESET_PC, imemReq=0, instr=0, pcPlus4=0, instrValid=0, skid buffer cleared, asynchronously.
REQ-034 rst mid-request: request abandoned; data returning after release is ignored until new FETCH.

Structure
REQ-035 Shared package mips_pkg: FSM encodings, pcSrc encodings (PC_SEQ, PC_JUMP, PC_JR), RESET_PC default.
REQ-036 Sub-module pc_target_calc: combinational target per REQ-020.

Verification
REQ-037 Reset release, imemReady always 1, memory word=addr: imemAddr 0,4,8,...; instr 0,4,8 one per cycle after IDLE.
REQ-038 beq (Branch=1, condZero=1, zero=1, exPc4=0x10, exImm=0xFFFE): next imemAddr=0x08, instrValid=0 one cycle.
REQ-039 bne not taken (condZero=0, zero=1): no redirect, sequential fetch continues.
REQ-040 jr (pcSrc=10, exRs=0x400) while imemReady low 3 cycles: imemAddr held, data discarded, next fetch 0x400.
REQ-041 stall high 4 cycles with imemReady=1: one word in HOLD, imemReq=0, outputs frozen; release -> buffered word next, no loss or duplication.
REQ-042 jump (pcSrc=01, exPc4=0x1000_0004, exTarget=0x100) concurrent with stall: flush, next imemAddr=0x1000_0400.
